// File: rtl/pipe_pkg.sv
// Shared definitions for handshaked pipeline stage registers.
// Holds the occupancy encoding and the default bubble instruction.
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  localparam logic [31:0] NOP_DEFAULT = 32'h0;

  // Skid valid implies main valid, so skid alone decides TWO.
  function automatic logic [1:0] slot_state(
    input logic main_v,
    input logic skid_v
  );
    if (skid_v) return ST_TWO;
    if (main_v) return ST_ONE;
    return ST_EMPTY;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// Single valid+data holding register for a pipeline stage.
// Clear wins over load; cleared data returns to CLR.
module pipe_slot #(
  parameter int W = 40,
  parameter logic [W-1:0] CLR = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] load_data,
  output logic         valid,
  output logic [W-1:0] data
);

  // Valid flag and payload, scrubbed whenever the slot empties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= CLR;
    end else if (clear) begin
      valid <= 1'b0;
      data  <= CLR;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Fetch/decode stage register with two-entry skid buffer.
// Registered in_ready, synchronous flush, saturating drop count.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR =
    INSTR_W'(NOP_DEFAULT),
  parameter int FCNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [FCNT_W-1:0]  flush_drops
);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } ent_t;

  localparam int EW = PC_W + INSTR_W;
  localparam logic [EW-1:0] CLR = {{PC_W{1'b0}}, NOP_INSTR};

  logic       main_v;
  logic       skid_v;
  ent_t       main_d;
  ent_t       skid_d;
  ent_t       in_d;
  ent_t       main_src;
  logic [1:0] state;
  logic       push;
  logic       pop;
  logic       main_load;
  logic       main_clear;
  logic       skid_load;
  logic       skid_clear;
  logic       next_two;
  logic [1:0] drop_n;
  logic [FCNT_W:0] drop_sum;

  assign state = slot_state(main_v, skid_v);
  assign push  = in_valid & in_ready;
  assign pop   = main_v & out_ready;

  assign in_d     = '{pc: in_pc, instr: in_instr};
  assign main_src = skid_v ? skid_d : in_d;

  // Slot control: flush empties both, else occupancy transitions.
  always_comb begin
    main_load  = 1'b0;
    main_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    next_two   = 1'b0;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      unique case (state)
        ST_EMPTY: main_load = push;
        ST_ONE: begin
          main_load  = push & pop;
          main_clear = pop & ~push;
          skid_load  = push & ~pop;
          next_two   = push & ~pop;
        end
        ST_TWO: begin
          main_load  = pop;
          skid_clear = pop;
          next_two   = ~pop;
        end
        default: ;
      endcase
    end
  end

  pipe_slot #(.W(EW), .CLR(CLR)) u_main (
    .clk       (clk),
    .rst       (rst),
    .load      (main_load),
    .clear     (main_clear),
    .load_data (main_src),
    .valid     (main_v),
    .data      (main_d)
  );

  pipe_slot #(.W(EW), .CLR(CLR)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .clear     (skid_clear),
    .load_data (in_d),
    .valid     (skid_v),
    .data      (skid_d)
  );

  // Ready only depends on next occupancy, never on out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_ready <= 1'b1;
    else     in_ready <= ~next_two;
  end

  assign drop_n = {1'b0, main_v}
                + {1'b0, skid_v}
                + {1'b0, push};
  assign drop_sum = {1'b0, flush_drops}
                  + {{(FCNT_W-1){1'b0}}, drop_n};

  // Count entries lost to flush, sticking at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_drops <= '0;
    end else if (flush) begin
      if (drop_sum[FCNT_W]) flush_drops <= '1;
      else flush_drops <= drop_sum[FCNT_W-1:0];
    end
  end

  assign out_valid = main_v;
  assign out_pc    = main_d.pc;
  assign out_instr = main_d.instr;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomized checks of pipe_stage_reg.
// Random phase compares against a queue reference model.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_pc;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_pc;
  logic [31:0] out_instr;
  logic [7:0]  flush_drops;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] instr;
  } ent_t;

  ent_t q[$];

  pipe_stage_reg dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_instr    (in_instr),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .flush_drops (flush_drops)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic       v,
    input logic [7:0] pc,
    input logic       rdy,
    input logic       fl
  );
    in_valid  = v;
    in_pc     = pc;
    in_instr  = 32'hA000_0000 + {24'h0, pc};
    out_ready = rdy;
    flush     = fl;
  endtask

  task automatic check(
    input string       tag,
    input logic        v,
    input logic [7:0]  pc,
    input logic [31:0] ins,
    input logic        rdy,
    input logic [7:0]  fd
  );
    checks++;
    assert (out_valid === v) else begin
      errors++;
      $error("FAIL %s out_valid obs=%0h exp=%0h",
             tag, out_valid, v);
    end
    checks++;
    assert (out_pc === pc) else begin
      errors++;
      $error("FAIL %s out_pc obs=%0h exp=%0h",
             tag, out_pc, pc);
    end
    checks++;
    assert (out_instr === ins) else begin
      errors++;
      $error("FAIL %s out_instr obs=%0h exp=%0h",
             tag, out_instr, ins);
    end
    checks++;
    assert (in_ready === rdy) else begin
      errors++;
      $error("FAIL %s in_ready obs=%0h exp=%0h",
             tag, in_ready, rdy);
    end
    checks++;
    assert (flush_drops === fd) else begin
      errors++;
      $error("FAIL %s flush_drops obs=%0h exp=%0h",
             tag, flush_drops, fd);
    end
  endtask

  initial begin
    logic [7:0] mdrops;
    int sz;
    logic p;
    logic exp_v;
    ent_t e;

    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    // Asynchronous reset seen before any clock edge.
    #3 rst = 1'b1;
    #1;
    check("reset", 1'b0, 8'h00, 32'h0, 1'b1, 8'd0);
    #3 rst = 1'b0;

    // Full-rate streaming, one entry per cycle.
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 8'(k), 1'b1, 1'b0);
      step();
      check($sformatf("stream%0d", k), 1'b1, 8'(k),
            32'hA000_0000 + k, 1'b1, 8'd0);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    step();
    check("drain", 1'b0, 8'h00, 32'h0, 1'b1, 8'd0);

    // Stall: two entries captured, then ready drops.
    drive(1'b1, 8'h10, 1'b0, 1'b0);
    step();
    check("stall_a", 1'b1, 8'h10, 32'hA000_0010,
          1'b1, 8'd0);
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    step();
    check("stall_b", 1'b1, 8'h10, 32'hA000_0010,
          1'b0, 8'd0);
    drive(1'b1, 8'h12, 1'b0, 1'b0);
    step();
    check("stall_c", 1'b1, 8'h10, 32'hA000_0010,
          1'b0, 8'd0);
    drive(1'b1, 8'h12, 1'b1, 1'b0);
    step();
    check("release_a", 1'b1, 8'h11, 32'hA000_0011,
          1'b1, 8'd0);
    step();
    check("release_b", 1'b1, 8'h12, 32'hA000_0012,
          1'b1, 8'd0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    step();
    check("release_c", 1'b0, 8'h00, 32'h0, 1'b1, 8'd0);

    // Flush in TWO with no input offered.
    drive(1'b1, 8'h20, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'h21, 1'b0, 1'b0);
    step();
    check("two_fill", 1'b1, 8'h20, 32'hA000_0020,
          1'b0, 8'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    step();
    check("flush_two", 1'b0, 8'h00, 32'h0, 1'b1, 8'd2);

    // Flush in ONE with an accepted input.
    drive(1'b1, 8'h30, 1'b0, 1'b0);
    step();
    check("one_fill", 1'b1, 8'h30, 32'hA000_0030,
          1'b1, 8'd2);
    drive(1'b1, 8'h31, 1'b0, 1'b1);
    step();
    check("flush_one", 1'b0, 8'h00, 32'h0, 1'b1, 8'd4);

    // Drive the drop counter up to 254.
    for (int i = 0; i < 125; i++) begin
      drive(1'b1, 8'h40, 1'b0, 1'b0);
      step();
      drive(1'b1, 8'h41, 1'b0, 1'b0);
      step();
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      step();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    step();
    check("cnt_254", 1'b0, 8'h00, 32'h0, 1'b1, 8'd254);

    // 254 + 2 saturates, further flushes hold.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 8'h50, 1'b0, 1'b0);
      step();
      drive(1'b1, 8'h51, 1'b0, 1'b0);
      step();
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      step();
      check($sformatf("sat%0d", i), 1'b0, 8'h00,
            32'h0, 1'b1, 8'd255);
    end

    // Reset with two entries held: all lost, count zeroed.
    drive(1'b1, 8'h60, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'h61, 1'b0, 1'b0);
    step();
    check("pre_rst", 1'b1, 8'h60, 32'hA000_0060,
          1'b0, 8'd255);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #3 rst = 1'b1;
    #1;
    check("mid_rst", 1'b0, 8'h00, 32'h0, 1'b1, 8'd0);
    #2 rst = 1'b0;

    // Random traffic against a queue reference model.
    mdrops = 8'd0;
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      in_pc     = 8'($urandom);
      in_instr  = $urandom;
      sz = q.size();
      p  = in_valid && (sz < 2);
      if (flush) begin
        if (int'(mdrops) + sz + int'(p) > 255)
          mdrops = 8'd255;
        else
          mdrops = mdrops + 8'(sz) + 8'(p);
        q.delete();
      end else begin
        if (sz > 0 && out_ready) void'(q.pop_front());
        if (p) q.push_back('{pc: in_pc, instr: in_instr});
      end
      step();
      exp_v = (q.size() > 0);
      e = exp_v ? q[0] : '{pc: 8'h00, instr: 32'h0};
      check($sformatf("rand%0d", c), exp_v, e.pc,
            e.instr, q.size() < 2, mdrops);
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
